axi4_lite_lsu_bridge: RTL and testbench
=======================================

# axi4_lite_lsu_bridge

Load/store bridge between the RV32IM core's memory stage and the AXI4-Lite master front end (`write_start`/`read_start` request interface). It converts one pipeline load or store into a single master transaction, generates byte strobes and lane-aligned store data, and extracts and sign/zero-extends load data. It stalls the pipeline until the transaction completes and flags misaligned accesses and bus timeouts.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width. Fixed at 32.
- `TIMEOUT_CYCLES`, 256, maximum cycles spent in WAIT before abort.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: load request, held stable while `stall`=1.
- `mem_write` in 1: store request, held stable while `stall`=1.
- `funct3` in 3: RV32 size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in ADDR_WIDTH: byte address.
- `store_data` in DATA_WIDTH: rs2 value, right-aligned.
- `stall` out 1: freezes the pipeline.
- `load_data` out DATA_WIDTH: extended load result.
- `misaligned` out 1: one-cycle pulse on an illegal alignment.
- `bus_error` out 1: one-cycle pulse on timeout.
- `write_start`, `write_addr`, `write_data`, `write_strobe[3:0]` out: to the master.
- `write_busy` in 1: from the master.
- `read_start`, `read_addr` out: to the master.
- `read_data` in DATA_WIDTH: from the master.
- `read_busy` in 1: from the master.

## Operation
- **FSM states:** IDLE, REQ, ARM, WAIT, DONE.
- **IDLE:**
  - Samples the request. `mem_write` has priority if both request lines are high.
  - Alignment rules: H/HU require `addr[0]`=0. W requires `addr[1:0]`=0. B has no constraint.
  - Misaligned request: `misaligned`=1 combinationally for that cycle, `stall`=0, no transaction, stay in IDLE.
  - Aligned request: `stall`=1 and latch `op`, `funct3`, `addr` and `store_data`. Next state REQ.
- **REQ:** asserts `write_start` or `read_start` for exactly one cycle. The address driven is `{addr[31:2],2'b00}`. Next state ARM.
- **ARM:** one guard cycle; busy is ignored. Next state WAIT.
- **WAIT:**
  - The selected busy input (`write_busy` or `read_busy`) equal to 0 means the transaction is complete. A load captures `read_data` into `load_data` on that edge. Next state DONE.
  - A cycle counter increments in WAIT. When it reaches `TIMEOUT_CYCLES`-1 while busy is still 1, go to DONE with `bus_error` pulsed in DONE. For a timed-out load, `load_data` is 0.
- **DONE:** `stall`=0 so the pipeline advances. Next state is IDLE unconditionally. A request present during DONE is ignored; it is re-sampled in IDLE.
- **Store encoding:**
  - SB: strobe `4'b0001<<addr[1:0]`, data `{4{sd[7:0]}}`.
  - SH: strobe `4'b0011<<{addr[1],1'b0}`, data `{2{sd[15:0]}}`.
  - SW: strobe `4'b1111`, data `sd`.
- **Load extraction:**
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **Output rules:**
  - `stall` = (IDLE and aligned request) or state ∈ {REQ, ARM, WAIT}.
  - `load_data` holds its last value until the next load completes.
  - `write_*`/`read_addr` are registered and stable from REQ through WAIT.
- **Undefined encodings:** `funct3` 011/110/111 are treated as W.

## Timing
- **Reset values:** state IDLE; `stall`=0, `load_data`=0, `misaligned`=0, `bus_error`=0, both starts 0, addr/data/strobe 0, counter 0.
- **Mid-operation reset:** returns to IDLE immediately (asynchronous) and issues no further start.
- **Cycle sequence** (request first seen in IDLE at cycle 0):
  - cycle 1: REQ, start pulse.
  - cycle 2: ARM.
  - cycle 3 onward: WAIT.
  - busy seen 0 at cycle N gives DONE at cycle N+1.
- **Minimum latency:** 4 cycles of stall, plus 1 DONE cycle.
- **Pulse widths:** start is exactly one cycle per accepted request; `misaligned` and `bus_error` are exactly one cycle.
- **Counter:** resets on entry to WAIT and saturates; the 9-bit width covers the default `TIMEOUT_CYCLES`.

## Test plan
- SW at 0x0000_0010 with 0xDEADBEEF, `write_busy` high cycles 2–5 → `write_addr`=0x10, `strobe`=1111, `data`=0xDEADBEEF, `write_start` pulse at cycle 1, DONE at cycle 7 with `stall`=0.
- SB at 0x13 with sd=0x000000A5 → `strobe`=1000, `write_data`=0xA5A5A5A5, `write_addr`=0x10.
- LB at 0x11 with `read_data`=0x0000_8000 → `load_data`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x12 with `read_data`=0xBEEF0000 → 0x0000BEEF.
- LW at 0x22 → `misaligned` pulse, `stall`=0, no `read_start`. SH at 0x21 → same behaviour.
- LW with `read_busy` stuck at 1 and `TIMEOUT_CYCLES`=8 → `bus_error` pulse, `load_data`=0, FSM returns to IDLE.
- `rst` asserted low during WAIT → all outputs at their reset values, and the next request starts cleanly from REQ.

Source files
------------

// File: rtl/axi4_lite_lsu_bridge.sv
// Load/store bridge: turns one pipeline load or store into a single AXI4-Lite master request,
// stalling the pipeline until completion and flagging misalignment and bus timeouts.
module axi4_lite_lsu_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  misaligned,
   output logic                  bus_error,
   output logic                  write_start,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [3:0]            write_strobe,
   input  logic                  write_busy,
   output logic                  read_start,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic                  read_busy
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StReq, StArm, StWait, StDone} state_e;

   state_e                state_q, state_d;
   logic                  op_write_q, op_write_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            lane_q, lane_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  bus_error_q, bus_error_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic                  write_start_q, write_start_d;
   logic                  read_start_q, read_start_d;
   logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic [3:0]            write_strobe_q, write_strobe_d;
   logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;

   logic                  req, size_byte, size_half, aligned, accept, busy_sel;
   logic [3:0]            strobe_new;
   logic [DATA_WIDTH-1:0] data_new;
   logic [DATA_WIDTH-1:0] load_ext;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;

   assign req       = mem_read | mem_write;
   assign size_byte = (funct3[1:0] == 2'b00);
   assign size_half = (funct3[1:0] == 2'b01);
   // Undefined size codes fall into the word case, so they need word alignment too.
   assign aligned   = size_byte | (size_half & ~addr[0]) |
                      (~size_byte & ~size_half & (addr[1:0] == 2'b00));
   assign accept    = (state_q == StIdle) & req & aligned;
   assign busy_sel  = op_write_q ? write_busy : read_busy;

   always_comb begin
      strobe_new = 4'b1111;
      data_new   = store_data;
      if (size_byte) begin
         strobe_new = 4'b0001 << addr[1:0];
         data_new   = {4{store_data[7:0]}};
      end else if (size_half) begin
         strobe_new = 4'b0011 << {addr[1], 1'b0};
         data_new   = {2{store_data[15:0]}};
      end
   end

   always_comb begin
      ld_byte  = read_data[7:0];
      unique case (lane_q)
         2'd0: ld_byte = read_data[7:0];
         2'd1: ld_byte = read_data[15:8];
         2'd2: ld_byte = read_data[23:16];
         2'd3: ld_byte = read_data[31:24];
         default: ld_byte = read_data[7:0];
      endcase
      ld_half  = lane_q[1] ? read_data[31:16] : read_data[15:0];
      load_ext = read_data;
      unique case (funct3_q)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_ext = {24'd0, ld_byte};
         3'b101:  load_ext = {16'd0, ld_half};
         default: load_ext = read_data;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      op_write_d     = op_write_q;
      funct3_d       = funct3_q;
      lane_d         = lane_q;
      cnt_d          = cnt_q;
      bus_error_d    = 1'b0;
      load_data_d    = load_data_q;
      write_start_d  = 1'b0;
      read_start_d   = 1'b0;
      write_addr_d   = write_addr_q;
      write_data_d   = write_data_q;
      write_strobe_d = write_strobe_q;
      read_addr_d    = read_addr_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d       = StReq;
               op_write_d    = mem_write;
               funct3_d      = funct3;
               lane_d        = addr[1:0];
               write_start_d = mem_write;
               read_start_d  = ~mem_write;
               if (mem_write) begin
                  write_addr_d   = {addr[ADDR_WIDTH-1:2], 2'b00};
                  write_data_d   = data_new;
                  write_strobe_d = strobe_new;
               end else begin
                  read_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
               end
            end
         end
         StReq: state_d = StArm;
         StArm: begin
            state_d = StWait;
            cnt_d   = '0;
         end
         StWait: begin
            if (!busy_sel) begin
               state_d = StDone;
               if (!op_write_q) load_data_d = load_ext;
            end else if (cnt_q == CntMax) begin
               state_d     = StDone;
               bus_error_d = 1'b1;
               if (!op_write_q) load_data_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= StIdle;
         op_write_q     <= 1'b0;
         funct3_q       <= 3'b000;
         lane_q         <= 2'b00;
         cnt_q          <= '0;
         bus_error_q    <= 1'b0;
         load_data_q    <= '0;
         write_start_q  <= 1'b0;
         read_start_q   <= 1'b0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_strobe_q <= 4'b0000;
         read_addr_q    <= '0;
      end else begin
         state_q        <= state_d;
         op_write_q     <= op_write_d;
         funct3_q       <= funct3_d;
         lane_q         <= lane_d;
         cnt_q          <= cnt_d;
         bus_error_q    <= bus_error_d;
         load_data_q    <= load_data_d;
         write_start_q  <= write_start_d;
         read_start_q   <= read_start_d;
         write_addr_q   <= write_addr_d;
         write_data_q   <= write_data_d;
         write_strobe_q <= write_strobe_d;
         read_addr_q    <= read_addr_d;
      end
   end

   assign stall        = accept | (state_q == StReq) | (state_q == StArm) | (state_q == StWait);
   assign misaligned   = (state_q == StIdle) & req & ~aligned;
   assign bus_error    = bus_error_q;
   assign load_data    = load_data_q;
   assign write_start  = write_start_q;
   assign read_start   = read_start_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;
   assign write_strobe = write_strobe_q;
   assign read_addr    = read_addr_q;

endmodule

// File: tb/tb_axi4_lite_lsu_bridge.sv
// Directed bench for axi4_lite_lsu_bridge: stores, loads, misalignment, timeout and mid-op reset.
module tb_axi4_lite_lsu_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        stall, misaligned, bus_error;
   logic [31:0] load_data;
   logic        write_start, write_busy, read_start, read_busy;
   logic [31:0] write_addr, write_data, read_addr, read_data;
   logic [3:0]  write_strobe;

   int checks = 0;
   int errors = 0;

   int          dc, st;
   logic        be;
   logic [31:0] oa, od;
   logic [3:0]  os;

   always #5 clk = ~clk;

   axi4_lite_lsu_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .addr(addr), .store_data(store_data), .stall(stall), .load_data(load_data),
      .misaligned(misaligned), .bus_error(bus_error), .write_start(write_start),
      .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe),
      .write_busy(write_busy), .read_start(read_start), .read_addr(read_addr),
      .read_data(read_data), .read_busy(read_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " stall"}, {31'd0, stall}, 32'd0);
      chk({tag, " misaligned"}, {31'd0, misaligned}, 32'd0);
      chk({tag, " bus_error"}, {31'd0, bus_error}, 32'd0);
      chk({tag, " starts"}, {30'd0, write_start, read_start}, 32'd0);
      chk({tag, " load_data"}, load_data, 32'd0);
      chk({tag, " write_addr"}, write_addr, 32'd0);
      chk({tag, " write_data"}, write_data, 32'd0);
      chk({tag, " write_strobe"}, {28'd0, write_strobe}, 32'd0);
      chk({tag, " read_addr"}, read_addr, 32'd0);
   endtask

   // Request at cycle 0; busy held high for cycles 2..1+nb; returns the cycle where stall drops.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a, sd, rd,
                        input int nb, output int done_cyc, output int starts, output logic berr,
                        output logic [31:0] o_addr, output logic [31:0] o_data,
                        output logic [3:0] o_strb);
      done_cyc = -1; starts = 0; berr = 1'b0; o_addr = '0; o_data = '0; o_strb = '0;
      @(posedge clk); #1;
      mem_write = wr; mem_read = ~wr; funct3 = f3; addr = a; store_data = sd; read_data = rd;
      write_busy = 1'b0; read_busy = 1'b0;
      @(negedge clk);
      if (write_start | read_start) starts++;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(posedge clk); #1;
         write_busy = wr & (c >= 2) & (c <= 1 + nb);
         read_busy  = ~wr & (c >= 2) & (c <= 1 + nb);
         @(negedge clk);
         if (write_start | read_start) starts++;
         if (c == 1) begin
            o_addr = wr ? write_addr : read_addr;
            o_data = write_data;
            o_strb = write_strobe;
         end
         if (!stall) begin
            done_cyc  = c;
            berr      = bus_error;
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
      end
      write_busy = 1'b0; read_busy = 1'b0;
   endtask

   initial begin
      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = '0;
      store_data = '0; write_busy = 1'b0; read_busy = 1'b0; read_data = '0;
      #12;
      chk_idle_outputs("reset");
      @(negedge clk); rst = 1'b1;

      // SW 0x10, busy cycles 2-5: DONE at cycle 7
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 4, dc, st, be, oa, od, os);
      chk("sw done_cycle", 32'(dc), 32'd7);
      chk("sw starts", 32'(st), 32'd1);
      chk("sw addr", oa, 32'h10);
      chk("sw data", od, 32'hDEADBEEF);
      chk("sw strobe", {28'd0, os}, 32'hF);

      // SB 0x13, minimum latency
      issue(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, dc, st, be, oa, od, os);
      chk("sb done_cycle", 32'(dc), 32'd4);
      chk("sb addr", oa, 32'h10);
      chk("sb data", od, 32'hA5A5A5A5);
      chk("sb strobe", {28'd0, os}, 32'h8);

      issue(1'b0, 3'b000, 32'h11, 32'h0, 32'h00008000, 2, dc, st, be, oa, od, os);
      chk("lb read_addr", oa, 32'h10);
      chk("lb starts", 32'(st), 32'd1);
      chk("lb load_data", load_data, 32'hFFFFFF80);

      issue(1'b0, 3'b100, 32'h11, 32'h0, 32'h00008000, 0, dc, st, be, oa, od, os);
      chk("lbu load_data", load_data, 32'h00000080);

      issue(1'b0, 3'b101, 32'h12, 32'h0, 32'hBEEF0000, 1, dc, st, be, oa, od, os);
      chk("lhu load_data", load_data, 32'h0000BEEF);

      issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hBEEF0000, 0, dc, st, be, oa, od, os);
      chk("lh load_data", load_data, 32'hFFFFBEEF);

      // SH 0x12: upper half lanes; load_data must hold across a store
      issue(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 0, dc, st, be, oa, od, os);
      chk("sh data", od, 32'h12341234);
      chk("sh strobe", {28'd0, os}, 32'hC);
      chk("sh load_data hold", load_data, 32'hFFFFBEEF);

      // Misaligned LW 0x22 and SH 0x21
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         mem_read = (k == 0); mem_write = (k == 1);
         funct3 = (k == 0) ? 3'b010 : 3'b001;
         addr = (k == 0) ? 32'h22 : 32'h21;
         @(negedge clk);
         chk("mis pulse", {31'd0, misaligned}, 32'd1);
         chk("mis stall", {31'd0, stall}, 32'd0);
         @(posedge clk); #1;
         mem_read = 1'b0; mem_write = 1'b0;
         @(negedge clk);
         chk("mis after", {29'd0, misaligned, write_start, read_start}, 32'd0);
      end

      // LW with read_busy stuck: timeout after 8 WAIT cycles, DONE at cycle 11
      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 100, dc, st, be, oa, od, os);
      chk("to done_cycle", 32'(dc), 32'd11);
      chk("to bus_error", {31'd0, be}, 32'd1);
      chk("to load_data", load_data, 32'd0);
      @(negedge clk);
      chk("to idle", {30'd0, bus_error, stall}, 32'd0);

      issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h5A5A1234, 0, dc, st, be, oa, od, os);
      chk("lw load_data", load_data, 32'h5A5A1234);

      // Reset asserted during WAIT
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40; read_busy = 1'b1;
      repeat (4) @(posedge clk);
      #2; rst = 1'b0; mem_read = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      @(negedge clk); rst = 1'b1; read_busy = 1'b0;
      @(negedge clk);
      chk("midrst no start", {30'd0, write_start, read_start}, 32'd0);
      issue(1'b1, 3'b010, 32'h44, 32'hCAFEF00D, 32'h0, 0, dc, st, be, oa, od, os);
      chk("post-rst done_cycle", 32'(dc), 32'd4);
      chk("post-rst starts", 32'(st), 32'd1);
      chk("post-rst addr", oa, 32'h44);
      chk("post-rst data", od, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
